// File: rtl/extram_fifo_pkg.sv
// Shared register map and bit positions for the extram FIFO bridge.
package extram_fifo_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_LEVEL = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int CTRL_TX_FLUSH   = 0;
  localparam int CTRL_RX_FLUSH   = 1;
  localparam int CTRL_IE_TXEMPTY = 8;
  localparam int CTRL_IE_RXAVAIL = 9;
  localparam int CTRL_IE_ERR     = 10;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_TX_OVF   = 2;
  localparam int STAT_RX_UNF   = 3;

  function automatic logic [15:0] swap_bytes(input logic [15:0] h);
    return {h[7:0], h[15:8]};
  endfunction

endpackage

// File: rtl/extram_fifo_bridge_sync_fifo.sv
// Single-clock FIFO on an inferred RAM; head is valid in the same cycle the
// pointer settles, so callers can read it combinationally.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic [DEPTH_LOG2-1:0] rd_addr_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    rd_addr_nxt = rd_addr_q;
    if (flush)
      rd_addr_nxt = '0;
    else if (pop_ok)
      rd_addr_nxt = rd_addr_q + DEPTH_LOG2'(1);
  end

  // The registered read address acts as the prefetch: after each edge it
  // already points at the next head, and the array read is write-first.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  assign head = mem[rd_addr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_addr_q <= '0;
      count     <= '0;
    end else begin
      rd_addr_q <= rd_addr_nxt;
      if (flush)
        wr_ptr <= '0;
      else if (push_ok)
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (flush)
        count <= '0;
      else begin
        case ({push_ok, pop_ok})
          2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
          2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/extram_fifo_bridge.sv
// CPU extram window to 16-bit host TX/RX streams via two sector-sized FIFOs.
// EXTRAM_FIFO_BYTESWAP_EN swaps bytes within each halfword at the host ports.
module extram_fifo_bridge
  import extram_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] extram_a,
  input  logic [31:0] extram_d_in,
  output logic [31:0] extram_d_out,
  input  logic        extram_cs,
  input  logic        extram_oe,
  input  logic [3:0]  extram_wstrb,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  logic [1:0]          reg_off;
  logic                acc_rd, acc_wr;
  logic                data_wr, data_rd;
  logic                ctrl_wr_b0, ctrl_wr_b1, stat_wr_b0;
  logic                tx_flush, rx_flush;

  logic                tx_full, tx_empty, tx_pop, tx_xfer, tx_half;
  logic [DEPTH_LOG2:0] tx_count;
  logic [31:0]         tx_head;
  logic [15:0]         tx_half_word;

  logic                rx_full, rx_empty, rx_push, rx_xfer, rx_pend;
  logic [DEPTH_LOG2:0] rx_count;
  logic [31:0]         rx_head;
  logic [15:0]         rx_h, rx_lo;

  logic [2:0]          ie_q;
  logic                tx_ovf, rx_unf;
  logic                irq_cond;

  assign reg_off    = extram_a[3:2];
  assign acc_rd     = extram_cs & extram_oe;
  assign acc_wr     = extram_cs & (|extram_wstrb);
  assign data_wr    = acc_wr & (reg_off == REG_DATA) & (extram_wstrb == 4'b1111);
  assign data_rd    = acc_rd & (reg_off == REG_DATA);
  assign ctrl_wr_b0 = acc_wr & (reg_off == REG_CTRL) & extram_wstrb[0];
  assign ctrl_wr_b1 = acc_wr & (reg_off == REG_CTRL) & extram_wstrb[1];
  assign stat_wr_b0 = acc_wr & (reg_off == REG_STAT) & extram_wstrb[0];
  assign tx_flush   = ctrl_wr_b0 & extram_d_in[CTRL_TX_FLUSH];
  assign rx_flush   = ctrl_wr_b0 & extram_d_in[CTRL_RX_FLUSH];

  // TX: 32-bit words in, low half then high half out
  assign tx_valid     = ~tx_empty;
  assign tx_xfer      = tx_valid & tx_ready;
  assign tx_pop       = tx_xfer & tx_half;
  assign tx_half_word = tx_half ? tx_head[31:16] : tx_head[15:0];

`ifdef EXTRAM_FIFO_BYTESWAP_EN
  assign tx_data = swap_bytes(tx_half_word);
  assign rx_h    = swap_bytes(rx_data);
`else
  assign tx_data = tx_half_word;
  assign rx_h    = rx_data;
`endif

  sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .din   (extram_d_in),
    .pop   (tx_pop),
    .flush (tx_flush),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  // RX: halfwords in, packed {second, first} into 32-bit words
  assign rx_ready = ~rx_full;
  assign rx_xfer  = rx_valid & rx_ready;
  assign rx_push  = rx_xfer & rx_pend;

  sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   ({rx_h, rx_lo}),
    .pop   (data_rd),
    .flush (rx_flush),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_ff @(posedge clk) begin
    if (rx_xfer & ~rx_pend)
      rx_lo <= rx_h;
  end

  assign irq_cond = (ie_q[0] & tx_empty) | (ie_q[1] & ~rx_empty) |
                    (ie_q[2] & (tx_ovf | rx_unf));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_half <= 1'b0;
      rx_pend <= 1'b0;
      ie_q    <= '0;
      tx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (tx_flush)
        tx_half <= 1'b0;
      else if (tx_xfer)
        tx_half <= ~tx_half;
      if (rx_flush)
        rx_pend <= 1'b0;
      else if (rx_xfer)
        rx_pend <= ~rx_pend;
      if (ctrl_wr_b1)
        ie_q <= extram_d_in[CTRL_IE_ERR:CTRL_IE_TXEMPTY];
      // Setting an error in the same cycle as its clear keeps it set
      tx_ovf <= (tx_ovf & ~(stat_wr_b0 & extram_d_in[STAT_TX_OVF])) | (data_wr & tx_full);
      rx_unf <= (rx_unf & ~(stat_wr_b0 & extram_d_in[STAT_RX_UNF])) | (data_rd & rx_empty);
      irq    <= irq_cond;
    end
  end

  always_comb begin
    extram_d_out = '0;
    case (reg_off)
      REG_DATA:  extram_d_out = rx_empty ? 32'h0 : rx_head;
      REG_LEVEL: extram_d_out = {16'(rx_count), 16'(tx_count)};
      REG_CTRL:  extram_d_out = {21'h0, ie_q, 8'h0};
      REG_STAT:  extram_d_out = {28'h0, rx_unf, tx_ovf, ~rx_empty, tx_empty};
      default:   extram_d_out = '0;
    endcase
  end

endmodule

// File: doc/extram_fifo_bridge.md
Name: extram_fifo_bridge

Overview:
- Slave on the CPU wrapper's external-register window (extram_* bus, mapped at 0xFFFFE000-0xFFFFFFFF).
- Bridges 32-bit CPU accesses to two 16-bit host-side streams toward the GD-ROM bus logic: a TX FIFO (CPU to host) and an RX FIFO (host to CPU).
- Raises an interrupt for ext_irq3 from FIFO status.
- Sized so one FIFO holds one 2048-byte sector.

Parameters:
- DEPTH_LOG2, 9, log2 of FIFO depth in 32-bit words (512 words = 2048 bytes) for each direction.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- extram_a  in  16  byte address; only [3:2] is decoded, so the 16-byte register block aliases across the window.
- extram_d_in  in  32  CPU write data.
- extram_d_out  out  32  read data; combinational from extram_a and current state.
- extram_cs  in  1  window select.
- extram_oe  in  1  read strobe; a read occurs when extram_cs && extram_oe.
- extram_wstrb  in  4  byte write strobes; a write occurs when extram_cs && wstrb != 0.
- tx_data  out  16  halfword to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts; a transfer occurs when tx_valid && tx_ready.
- rx_data  in  16  halfword from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts.
- irq  out  1  level interrupt; wired to ext_irq3.

Behaviour:
- Register map (word offset = extram_a[3:2]):
  - 0 DATA: a write pushes TX; a read pops RX.
  - 1 LEVEL: [15:0] TX word count, [31:16] RX word count, zero-extended.
  - 2 CTRL: bit0 TX_FLUSH, bit1 RX_FLUSH (write 1, self-clearing, always read 0); bit8 IE_TXEMPTY, bit9 IE_RXAVAIL, bit10 IE_ERR (R/W).
  - 3 STAT: bit0 TX_EMPTY, bit1 RX_AVAIL (RX count != 0), bit2 TX_OVF, bit3 RX_UNF. Bits 2 and 3 are sticky and cleared by writing 1 (W1C). All other bits read 0.
- Every access is exactly one cycle; the bus has no wait states.
- Read data is valid combinationally in the cycle of the access. Pops and side effects take effect at the end of that cycle.
- DATA write:
  - Pushes only when wstrb == 4'b1111; other wstrb values are ignored.
  - A push while TX is full is dropped and sets TX_OVF. Fullness is evaluated before the edge, so a simultaneous host pop does not make room.
- DATA read:
  - Returns the RX head word and pops it.
  - If RX is empty, returns 0, sets RX_UNF and does not pop.
- CTRL/STAT writes honour only wstrb[0] (bits 7:0) and wstrb[1] (bits 15:8).
- TX unpack (32 to 16):
  - tx_valid = TX not empty.
  - tx_data = half ? word[31:16] : word[15:0].
  - The half flag starts at 0. On a transfer with half=0, half becomes 1. On a transfer with half=1, the word is popped and half becomes 0.
- RX pack (16 to 32):
  - rx_ready = !rx_full.
  - The first halfword goes into the lo holding register and sets the pend flag.
  - The second halfword pushes {rx_data, lo} and clears pend.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- Count range is 0..2^DEPTH_LOG2. Pointers are DEPTH_LOG2 bits and wrap modulo the depth.
- Flush:
  - TX_FLUSH zeroes the TX pointers, count and half flag. RX_FLUSH zeroes the RX pointers, count and pend flag.
  - Flush wins over any push or pop in the same cycle.
  - Flush does not clear the sticky error flags.
- irq = (IE_TXEMPTY & TX_EMPTY) | (IE_RXAVAIL & RX_AVAIL) | (IE_ERR & (TX_OVF | RX_UNF)). irq is registered, so it lags the condition by 1 cycle.
- Reset values:
  - FIFOs empty, half = 0, pend = 0, CTRL = 0, sticky flags = 0, irq = 0.
  - tx_valid = 0, rx_ready = 1.
  - Reset mid-transfer discards all data.
- FIFO storage is inferred block RAM with a registered read address, so a lookahead/prefetch head register is required to keep reads combinational.

Optional Feature:
- Macro: EXTRAM_FIFO_BYTESWAP_EN.
- Defined: bytes are swapped within each 16-bit halfword at both host ports (tx_data = {b0, b1}; rx_data is swapped before packing). This suits the big-endian host-bus ordering.
- Undefined: halfwords pass through unchanged.

Decomposition:
- Package extram_fifo_pkg holds:
  - register offset constants (REG_DATA=0, REG_LEVEL=1, REG_CTRL=2, REG_STAT=3);
  - CTRL/STAT bit index constants.
- Sub-module sync_fifo (parameter WIDTH=32, DEPTH_LOG2): push, pop, flush, full, empty, count, head. It is instantiated twice.

Test Plan:
- Write 0x11223344 to DATA with tx_ready=1 -> tx_data 0x3344 then 0x1122 on consecutive cycles; TX_EMPTY=1 after; irq=1 one cycle later if IE_TXEMPTY=1.
- Host sends 0xBEEF then 0xCAFE -> LEVEL[31:16]=1; DATA read returns 0xCAFEBEEF; LEVEL[31:16] returns to 0.
- Push 512 words with tx_ready=0, then a 513th -> LEVEL[15:0]=512; STAT.TX_OVF=1; the 513th word is never emitted; writing 0x4 to STAT clears TX_OVF.
- Read DATA with RX empty -> returns 0; RX_UNF=1; with IE_ERR=1, irq asserts.
- Write TX_FLUSH while TX holds 3 words and half=1 -> next cycle LEVEL[15:0]=0 and tx_valid=0; a later push starts from the low half.
- Byte write (wstrb=4'b0001) to DATA -> no push; LEVEL unchanged. With EXTRAM_FIFO_BYTESWAP_EN defined, word 0x11223344 yields 0x4433 then 0x2211.
